// File: rtl/nonce_dispatch_ctrl.sv
// Nonce dispatcher: sequences hash cores over equal nonce slices and
// arbitrates their golden results into a small FIFO for the UART path.
module nonce_dispatch_ctrl #(
  parameter int NCORES     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   hash_clk,
  input  logic                   reset_n,
  input  logic                   start_mining,
  input  logic                   work_valid,
  output logic [NCORES-1:0]      core_load,
  output logic [31:0]            core_nonce_base,
  input  logic [NCORES-1:0]      core_busy,
  input  logic [NCORES-1:0]      golden_valid,
  input  logic [32*NCORES-1:0]   golden_nonce,
  output logic [NCORES-1:0]      golden_ack,
  output logic                   result_valid,
  output logic [31:0]            result_nonce,
  input  logic                   result_ready,
  output logic                   mining
);

  localparam int IW = $clog2(NCORES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [1:0]        guard_q;
  logic              start_q;
  logic [NCORES-1:0] core_load_q;
  logic [31:0]       base_q;
  logic              mining_q;

  logic [IW-1:0]     rr_q;
  logic [NCORES-1:0] ack_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;

  logic              start_edge;
  logic [IW-1:0]     idx_inc;
  logic              run_exhausted;

  function automatic logic [NCORES-1:0] onehot(input logic [IW-1:0] i);
    logic [NCORES-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Each core owns an equal slice: base is the index in the top bits.
  function automatic logic [31:0] slice_base(input logic [IW-1:0] i);
    return {i, {(32-IW){1'b0}}};
  endfunction

  assign start_edge    = start_mining & ~start_q;
  assign idx_inc       = idx_q + IW'(1);
  assign run_exhausted = (guard_q == 2'd2) & ~|core_busy;

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      guard_q     <= '0;
      start_q     <= 1'b0;
      core_load_q <= '0;
      base_q      <= '0;
      mining_q    <= 1'b0;
    end else begin
      start_q     <= start_mining;
      core_load_q <= '0;
      base_q      <= '0;
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            core_load_q <= onehot('0);
          end
        end
        LOAD: begin
          if (idx_q == IW'(NCORES-1)) begin
            state_q  <= RUN;
            guard_q  <= '0;
            mining_q <= 1'b1;
          end else begin
            idx_q       <= idx_inc;
            core_load_q <= onehot(idx_inc);
            base_q      <= slice_base(idx_inc);
          end
        end
        RUN: begin
          if (work_valid || start_edge) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            core_load_q <= onehot('0);
            mining_q    <= 1'b0;
          end else if (run_exhausted) begin
            state_q  <= IDLE;
            mining_q <= 1'b0;
          end else if (guard_q != 2'd2) begin
            guard_q <= guard_q + 2'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          mining_q <= 1'b0;
        end
      endcase
    end
  end

  logic [NCORES-1:0] req;
  logic              gnt_found;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     cand;
  logic              full;
  logic              grant;
  logic              pop;
  logic [31:0]       gnt_nonce;

  // A core just acked still shows valid for one cycle; mask it out.
  assign req = golden_valid & ~ack_q;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NCORES; k++) begin
      cand = rr_q + IW'(k);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign grant     = gnt_found & ~full;
  assign pop       = (cnt_q != '0) & result_ready;
  assign gnt_nonce = golden_nonce[32*int'(gnt_idx) +: 32];

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q  <= '0;
      ack_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ack_q <= '0;
      if (grant) begin
        ack_q        <= onehot(gnt_idx);
        mem_q[wr_q]  <= gnt_nonce;
        wr_q         <= wr_q + PW'(1);
        rr_q         <= gnt_idx + IW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      unique case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign core_load       = core_load_q;
  assign core_nonce_base = base_q;
  assign mining          = mining_q;
  assign golden_ack      = ack_q;
  assign result_valid    = (cnt_q != '0);
  assign result_nonce    = mem_q[rd_q];

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Bench for nonce_dispatch_ctrl: directed scenarios plus a randomized
// arbitration run checked against a queue-based result model.
module tb_nonce_dispatch_ctrl;

  localparam int NC = 4;
  localparam int FD = 4;

  logic            hash_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start_mining = 1'b0;
  logic            work_valid = 1'b0;
  logic            result_ready = 1'b0;
  logic [NC-1:0]   core_busy = '0;
  logic [NC-1:0]   golden_valid = '0;
  logic [32*NC-1:0] golden_nonce = '0;
  logic [NC-1:0]   core_load;
  logic [31:0]     core_nonce_base;
  logic [NC-1:0]   golden_ack;
  logic            result_valid;
  logic [31:0]     result_nonce;
  logic            mining;

  int n_cmp = 0;
  int n_fail = 0;

  nonce_dispatch_ctrl #(.NCORES(NC), .FIFO_DEPTH(FD)) dut (
    .hash_clk(hash_clk),
    .reset_n(reset_n),
    .start_mining(start_mining),
    .work_valid(work_valid),
    .core_load(core_load),
    .core_nonce_base(core_nonce_base),
    .core_busy(core_busy),
    .golden_valid(golden_valid),
    .golden_nonce(golden_nonce),
    .golden_ack(golden_ack),
    .result_valid(result_valid),
    .result_nonce(result_nonce),
    .result_ready(result_ready),
    .mining(mining)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic step();
    @(posedge hash_clk);
    @(negedge hash_clk);
  endtask

  task automatic test_reset();
    logic [72:0] outs;
    reset_n = 1'b0;
    step();
    step();
    outs = {core_load, core_nonce_base, golden_ack, result_valid,
            result_nonce[31:0] != 0, mining};
    n_cmp++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    n_cmp++;
    if (result_nonce !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_nonce: got %h want 0", result_nonce);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_arb_order();
    logic [31:0] nz [NC];
    logic [31:0] got [$];
    for (int i = 0; i < NC; i++) begin
      nz[i] = ($urandom & 32'hFFFF_FFF0) | 32'(i);
      golden_nonce[32*i +: 32] = nz[i];
    end
    golden_valid = '1;
    result_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c < NC) begin
        n_cmp++;
        if (golden_ack !== (NC'(1) << c)) begin
          n_fail++;
          $display("FAIL arb_ack%0d: got %b want %b", c, golden_ack,
                   NC'(1) << c);
        end
      end
      golden_valid = golden_valid & ~golden_ack;
      if (result_valid && result_ready) got.push_back(result_nonce);
    end
    n_cmp++;
    if (got.size() != NC) begin
      n_fail++;
      $display("FAIL arb_count: got %0d want %0d", got.size(), NC);
    end else begin
      for (int i = 0; i < NC; i++) begin
        n_cmp++;
        if (got[i] !== nz[i]) begin
          n_fail++;
          $display("FAIL arb_result%0d: got %h want %h", i, got[i], nz[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] nz [NC+1];
    logic [31:0] exp [$];
    logic [31:0] got [$];
    for (int i = 0; i <= NC; i++) nz[i] = ($urandom & 32'hFFFF_FF00) | 32'(i + 8'h40);
    for (int i = 0; i < NC; i++) golden_nonce[32*i +: 32] = nz[i];
    result_ready = 1'b0;
    golden_valid = '1;
    for (int c = 1; c <= NC; c++) begin
      step();
      n_cmp++;
      if (golden_ack !== (NC'(1) << (c - 1))) begin
        n_fail++;
        $display("FAIL bp_ack%0d: got %b want %b", c, golden_ack,
                 NC'(1) << (c - 1));
      end
      golden_valid = golden_valid & ~golden_ack;
      if (c == 2) begin
        golden_valid[0] = 1'b1;
        golden_nonce[31:0] = nz[NC];
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (golden_ack !== '0 || result_valid !== 1'b1 ||
          result_nonce !== nz[0]) begin
        n_fail++;
        $display("FAIL bp_stall%0d: ack=%b valid=%b head=%h want 0/1/%h",
                 c, golden_ack, result_valid, result_nonce, nz[0]);
      end
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    n_cmp++;
    if (golden_ack !== '0 || result_nonce !== nz[1]) begin
      n_fail++;
      $display("FAIL bp_pop: ack=%b head=%h want 0000/%h", golden_ack,
               result_nonce, nz[1]);
    end
    step();
    n_cmp++;
    if (golden_ack !== NC'(1)) begin
      n_fail++;
      $display("FAIL bp_fifth_ack: got %b want %b", golden_ack, NC'(1));
    end
    golden_valid = '0;
    exp = '{nz[1], nz[2], nz[3], nz[NC]};
    result_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (result_valid && result_ready) got.push_back(result_nonce);
      step();
    end
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d items want %0d in order", got.size(),
               exp.size());
    end
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got %b want 0", result_valid);
    end
  endtask

  task automatic test_load();
    logic [31:0] eb;
    core_busy = '1;
    start_mining = 1'b1;
    for (int i = 0; i < NC; i++) begin
      step();
      eb = 32'(longint'(i) * (64'h1_0000_0000 / NC));
      n_cmp++;
      if (core_load !== (NC'(1) << i) || core_nonce_base !== eb ||
          mining !== 1'b0) begin
        n_fail++;
        $display("FAIL load%0d: load=%b base=%h mining=%b want %b/%h/0", i,
                 core_load, core_nonce_base, mining, NC'(1) << i, eb);
      end
    end
    step();
    n_cmp++;
    if (mining !== 1'b1 || core_load !== '0 || core_nonce_base !== '0) begin
      n_fail++;
      $display("FAIL load_run: mining=%b load=%b base=%h want 1/0/0", mining,
               core_load, core_nonce_base);
    end
  endtask

  task automatic test_exhaust();
    bit gone;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (mining !== 1'b1 || core_load !== '0) begin
        n_fail++;
        $display("FAIL busy_hold%0d: mining=%b load=%b want 1/0", c, mining,
                 core_load);
      end
    end
    core_busy = '0;
    step();
    n_cmp++;
    if (mining !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust: mining=%b want 0", mining);
    end
    step();
    n_cmp++;
    if (mining !== 1'b0 || core_load !== '0) begin
      n_fail++;
      $display("FAIL no_restart: mining=%b load=%b want 0/0", mining,
               core_load);
    end
    start_mining = 1'b0;
    step();
    start_mining = 1'b1;
    for (int i = 0; i < NC; i++) step();
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (mining !== 1'b1) begin
        n_fail++;
        $display("FAIL guard%0d: mining=%b want 1", c, mining);
      end
    end
    gone = 1'b0;
    for (int c = 0; c < 4 && !gone; c++) begin
      step();
      gone = (mining == 1'b0);
    end
    n_cmp++;
    if (!gone) begin
      n_fail++;
      $display("FAIL guard_expire: mining=%b want 0 within 4 cycles", mining);
    end
    start_mining = 1'b0;
    step();
  endtask

  task automatic test_work_priority();
    bit gone;
    core_busy = '1;
    start_mining = 1'b1;
    for (int i = 0; i < NC + 1; i++) step();
    for (int c = 0; c < 3; c++) step();
    core_busy = '0;
    work_valid = 1'b1;
    step();
    work_valid = 1'b0;
    n_cmp++;
    if (core_load !== NC'(1) || mining !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load0: load=%b mining=%b want %b/0", core_load,
               mining, NC'(1));
    end
    for (int i = 1; i < NC; i++) begin
      step();
      n_cmp++;
      if (core_load !== (NC'(1) << i)) begin
        n_fail++;
        $display("FAIL prio_load%0d: got %b want %b", i, core_load,
                 NC'(1) << i);
      end
    end
    step();
    n_cmp++;
    if (mining !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_run: mining=%b want 1", mining);
    end
    start_mining = 1'b0;
    gone = 1'b0;
    for (int c = 0; c < 10 && !gone; c++) begin
      step();
      gone = (mining == 1'b0);
    end
    n_cmp++;
    if (!gone) begin
      n_fail++;
      $display("FAIL prio_idle: mining=%b want 0", mining);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [NC-1:0] any_load;
    start_mining = 1'b1;
    step();
    step();
    step();
    n_cmp++;
    if (core_load !== 4'b0100) begin
      n_fail++;
      $display("FAIL midload_third: got %b want 0100", core_load);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (core_load !== '0 || core_nonce_base !== '0 || mining !== 1'b0 ||
        golden_ack !== '0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: load=%b base=%h mining=%b want all 0",
               core_load, core_nonce_base, mining);
    end
    start_mining = 1'b0;
    @(negedge hash_clk);
    step();
    reset_n = 1'b1;
    any_load = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      any_load = any_load | core_load;
    end
    n_cmp++;
    if (any_load !== '0) begin
      n_fail++;
      $display("FAIL no_reload: got %b want 0000", any_load);
    end
    reset_n = 1'b0;
    start_mining = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (core_load !== NC'(1)) begin
      n_fail++;
      $display("FAIL start_at_release: got %b want %b", core_load, NC'(1));
    end
    for (int i = 0; i < NC; i++) step();
    n_cmp++;
    if (mining !== 1'b1) begin
      n_fail++;
      $display("FAIL release_run: mining=%b want 1", mining);
    end
    start_mining = 1'b0;
  endtask

  task automatic test_random_arb();
    int          rr_m;
    logic [31:0] q [$];
    logic [NC-1:0] exp_ack;
    logic [31:0] gn;
    bit          pop;
    reset_n = 1'b0;
    golden_valid = '0;
    result_ready = 1'b0;
    step();
    reset_n = 1'b1;
    rr_m = 0;
    exp_ack = '0;
    gn = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++;
      if (golden_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL rnd_ack@%0d: got %b want %b", cyc, golden_ack,
                 exp_ack);
      end
      n_cmp++;
      if (result_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_valid@%0d: got %b want %b", cyc, result_valid,
                 q.size() != 0);
      end else if (q.size() != 0 && result_nonce !== q[0]) begin
        n_fail++;
        $display("FAIL rnd_head@%0d: got %h want %h", cyc, result_nonce,
                 q[0]);
      end
      golden_valid = golden_valid & ~golden_ack;
      for (int i = 0; i < NC; i++) begin
        if (!golden_valid[i] && !golden_ack[i] &&
            $urandom_range(0, 3) == 0) begin
          golden_valid[i] = 1'b1;
          golden_nonce[32*i +: 32] = $urandom;
        end
      end
      if (cyc < 200) result_ready = ($urandom_range(0, 4) == 0);
      else           result_ready = ($urandom_range(0, 1) == 1);
      pop = (q.size() != 0) && result_ready;
      exp_ack = '0;
      if (q.size() < FD) begin
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (rr_m + k) % NC;
          if (exp_ack == '0 && golden_valid[c]) begin
            exp_ack[c] = 1'b1;
            gn = golden_nonce[32*c +: 32];
          end
        end
        for (int c = 0; c < NC; c++) if (exp_ack[c]) rr_m = (c + 1) % NC;
      end
      if (pop) void'(q.pop_front());
      if (exp_ack != '0) q.push_back(gn);
      step();
    end
    golden_valid = '0;
    result_ready = 1'b0;
  endtask

  initial begin
    @(negedge hash_clk);
    test_reset();
    test_arb_order();
    test_backpressure();
    test_load();
    test_exhaust();
    test_work_priority();
    test_reset_mid_load();
    test_random_arb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
